// File: rtl/bus_arbiter_if.sv
// Coherence-bus request/grant bundle between two CPUs and the bus arbiter.
// master = requester side (CPUs / bus controller), slave = arbiter side.
interface bus_arbiter_if;
  logic       req_0;
  logic       req_1;
  logic [2:0] op_0;
  logic [2:0] op_1;
  logic       done;
  logic       grant_0;
  logic       grant_1;
  logic [2:0] bus_op;
  logic       bus_owner;
  logic       bus_busy;
  logic       timeout_err;

  modport master (
    output req_0, req_1, op_0, op_1, done,
    input  grant_0, grant_1, bus_op, bus_owner, bus_busy, timeout_err
  );

  modport slave (
    input  req_0, req_1, op_0, op_1, done,
    output grant_0, grant_1, bus_op, bus_owner, bus_busy, timeout_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-CPU round-robin coherence-bus arbiter with registered outputs.
// Optional forced release after HOLD_MAX owner cycles when ARB_TIMEOUT_EN is defined.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | bus free; sample requests, pick a winner
//   OWN     | one CPU holds the bus; op/owner frozen, hold counter runs
//   RELEASE | one-cycle gap with grants low; last_owner updated
module bus_arbiter #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  bus
);

  if (HOLD_MAX < 2 || HOLD_MAX > 15) begin : g_hold_max_check
    $error("bus_arbiter: HOLD_MAX must be in 2..15");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [2:0] OP_NOOP = 3'b000;

  state_t     state_q, state_d;
  logic       grant0_q, grant0_d;
  logic       grant1_q, grant1_d;
  logic [2:0] op_q, op_d;
  logic       owner_q, owner_d;
  logic       busy_q, busy_d;
  logic [3:0] hold_q, hold_d;
  logic       last_q, last_d;
  logic       win;
  logic       release_now;

`ifdef ARB_TIMEOUT_EN
  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);
  logic       tmo_q, tmo_d;
`endif

  always_comb begin
    state_d     = state_q;
    grant0_d    = grant0_q;
    grant1_d    = grant1_q;
    op_d        = op_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    hold_d      = hold_q;
    last_d      = last_q;
    win         = 1'b0;
    release_now = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tmo_d       = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        grant0_d = 1'b0;
        grant1_d = 1'b0;
        op_d     = OP_NOOP;
        busy_d   = 1'b0;
        hold_d   = 4'd0;
        if (bus.req_0 || bus.req_1) begin
          // On contention the CPU that did not own the bus last time wins.
          win      = (bus.req_0 && bus.req_1) ? ~last_q : bus.req_1;
          state_d  = OWN;
          grant0_d = ~win;
          grant1_d = win;
          op_d     = win ? bus.op_1 : bus.op_0;
          owner_d  = win;
          busy_d   = 1'b1;
          hold_d   = 4'd1;
        end
      end

      OWN: begin
        if (hold_q != 4'd15) hold_d = hold_q + 4'd1;
        if (bus.done && hold_q >= 4'd2) begin
          release_now = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q >= HOLD_LIM) begin
          release_now = 1'b1;
          tmo_d       = 1'b1;
        end
`endif
        if (release_now) begin
          state_d  = RELEASE;
          grant0_d = 1'b0;
          grant1_d = 1'b0;
          op_d     = OP_NOOP;
          busy_d   = 1'b0;
          hold_d   = 4'd0;
        end
      end

      RELEASE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        grant0_d = 1'b0;
        grant1_d = 1'b0;
        op_d     = OP_NOOP;
        busy_d   = 1'b0;
        hold_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      op_q     <= OP_NOOP;
      owner_q  <= 1'b0;
      busy_q   <= 1'b0;
      hold_q   <= 4'd0;
      last_q   <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      op_q     <= op_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
`ifdef ARB_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign bus.grant_0   = grant0_q;
  assign bus.grant_1   = grant1_q;
  assign bus.bus_op    = op_q;
  assign bus.bus_owner = owner_q;
  assign bus.bus_busy  = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout_err = tmo_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed vector table plus hand sequences and random traffic for bus_arbiter.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_arbiter_if bif ();

`ifdef ARB_TIMEOUT_EN
  localparam int HM = 4;
`else
  localparam int HM = 15;
`endif

  bus_arbiter #(.HOLD_MAX(HM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct {
    logic       r0;
    logic       r1;
    logic [2:0] o0;
    logic [2:0] o1;
    logic       dn;
    logic       g0;
    logic       g1;
    logic [2:0] bop;
    logic       own;
    logic       busy;
  } vec_t;

  localparam int NV = 19;
  vec_t vec [NV];

  int n_vec = 0;
  int n_err = 0;

  // Compares {g0,g1,bus_op,owner,busy,timeout}; owner is masked when bus not busy.
  task automatic expect_outs(input string tag, input logic g0, input logic g1,
                             input logic [2:0] bop, input logic own,
                             input logic busy, input logic tmo);
    logic [7:0] act, exp;
    logic       own_act;
    own_act = busy ? bif.bus_owner : own;
    act = {bif.grant_0, bif.grant_1, bif.bus_op, own_act, bif.bus_busy, bif.timeout_err};
    exp = {g0, g1, bop, own, busy, tmo};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got g0g1_op_own_busy_tmo=%b required %b", tag, act, exp);
    end
  endtask

  task automatic cmp_int(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", tag, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic r1, input logic [2:0] o0,
                       input logic [2:0] o1, input logic dn);
    @(negedge clk);
    bif.req_0 = r0;
    bif.req_1 = r1;
    bif.op_0  = o0;
    bif.op_1  = o1;
    bif.done  = dn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int viol_mutex, viol_stable, viol_busy, grants_seen;
  logic pg0, pg1;
  logic [2:0] pop;

  initial begin
    //            r0    r1    o0    o1    dn  |  g0    g1    bop   own   busy
    vec[0]  = '{1'b1, 1'b0, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1};
    vec[1]  = '{1'b0, 1'b0, 3'd5, 3'd0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1};
    vec[2]  = '{1'b0, 1'b0, 3'd5, 3'd0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1};
    vec[3]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vec[6]  = '{1'b1, 1'b1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1};
    vec[7]  = '{1'b1, 1'b0, 3'd2, 3'd6, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1};
    vec[8]  = '{1'b1, 1'b0, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vec[9]  = '{1'b1, 1'b0, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vec[10] = '{1'b1, 1'b0, 3'd2, 3'd0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1};
    vec[11] = '{1'b0, 1'b1, 3'd0, 3'd4, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1};
    vec[12] = '{1'b0, 1'b1, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vec[13] = '{1'b0, 1'b1, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vec[14] = '{1'b1, 1'b1, 3'd6, 3'd4, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1};
    vec[15] = '{1'b1, 1'b0, 3'd6, 3'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1};
    vec[16] = '{1'b1, 1'b0, 3'd6, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vec[17] = '{1'b1, 1'b0, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vec[18] = '{1'b1, 1'b1, 3'd6, 3'd4, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 1'b1};

    bif.req_0 = 1'b0; bif.req_1 = 1'b0;
    bif.op_0  = 3'd0; bif.op_1  = 3'd0;
    bif.done  = 1'b0;

    #12;
    expect_outs("reset", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].r0, vec[i].r1, vec[i].o0, vec[i].o1, vec[i].dn);
      tick();
      expect_outs($sformatf("vec%0d", i), vec[i].g0, vec[i].g1, vec[i].bop,
                  vec[i].own, vec[i].busy, 1'b0);
    end

    // cpu0 owns (op 6); release it, then grant cpu1 and hit reset mid-ownership.
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b0); tick();
    expect_outs("seqA_hold", 1'b1, 1'b0, 3'd6, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b1); tick();
    expect_outs("seqA_rel", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 3'd0, 3'd7, 1'b0); tick();
    expect_outs("seqA_idle", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 3'd0, 3'd7, 1'b0); tick();
    expect_outs("seqA_g1", 1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    expect_outs("rst_async", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    cmp_int("rst_owner", int'(bif.bus_owner), 0);
    @(negedge clk);
    rst = 1'b0;
    bif.req_0 = 1'b1; bif.req_1 = 1'b1;
    bif.op_0  = 3'd3; bif.op_1  = 3'd5;
    bif.done  = 1'b0;
    tick();
    expect_outs("post_rst_rr", 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);

    // cpu0 now in its first OWN cycle with no done forthcoming.
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b0); tick();
      expect_outs($sformatf("tmo_hold%0d", k), 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b0); tick();
    expect_outs("tmo_release", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b0); tick();
    expect_outs("tmo_once", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
`else
    for (int k = 1; k <= 16; k++) begin
      drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b0); tick();
      expect_outs($sformatf("hold%0d", k), 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
    end
    // 17th OWN cycle: a wrapping counter would read 1 here and ignore done.
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b1); tick();
    expect_outs("sat_done", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b0); tick();
    expect_outs("sat_idle", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
`endif

    viol_mutex = 0; viol_stable = 0; viol_busy = 0; grants_seen = 0;
    pg0 = 1'b0; pg1 = 1'b0; pop = 3'd0;
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0));
      tick();
      if (bif.grant_0 && bif.grant_1) viol_mutex++;
      if (bif.bus_busy !== (bif.grant_0 | bif.grant_1)) viol_busy++;
      if (((bif.grant_0 && pg0) || (bif.grant_1 && pg1)) && bif.bus_op !== pop)
        viol_stable++;
      if (bif.grant_0 || bif.grant_1) grants_seen++;
      pg0 = bif.grant_0; pg1 = bif.grant_1; pop = bif.bus_op;
    end
    cmp_int("rand_mutex", viol_mutex, 0);
    cmp_int("rand_busy", viol_busy, 0);
    cmp_int("rand_op_stable", viol_stable, 0);
    cmp_int("rand_traffic", int'(grants_seen > 1000), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 15, max cycles one owner may hold the bus before a forced release (range 2..15).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 req_0  input  1  cpu0 requests the coherence bus; level, held until granted.
REQ-005 req_1  input  1  cpu1 requests the coherence bus; level, held until granted.
REQ-006 op_0  input  3  cpu0 requested bus operation (bus_op_t encoding; 000 = NOOP).
REQ-007 op_1  input  3  cpu1 requested bus operation.
REQ-008 done  input  1  one-cycle pulse from the bus controller: current transaction complete.
REQ-009 grant_0  output  1  cpu0 owns the bus.
REQ-010 grant_1  output  1  cpu1 owns the bus.
REQ-011 bus_op  output  3  operation latched from the owner at grant; NOOP when idle.
REQ-012 bus_owner  output  1  0 = cpu0, 1 = cpu1; valid only while bus_busy.
REQ-013 bus_busy  output  1  high while either grant is high.
REQ-014 timeout_err  output  1  one-cycle pulse on forced release.

Function
REQ-015 All outputs SHALL be driven from flops; no combinational input-to-output path.
REQ-016 The FSM SHALL have three states: IDLE, OWN, RELEASE.
REQ-017 IDLE: with no request, stay in IDLE with grants low and bus_op = NOOP.
REQ-018 IDLE with exactly one req sampled high: go to OWN; that grant rises on the next clock edge (1-cycle latency).
REQ-019 IDLE with both reqs high: grant the requester that is not last_owner (round robin).
REQ-020 On entry to OWN, latch the winner's op into bus_op and its id into bus_owner.
REQ-021 OWN: hold the grant, bus_op and bus_owner stable; a 4-bit hold counter starts at 1 on entry and increments each cycle, saturating at 15.
REQ-022 OWN: ignore done while the hold counter equals 1, so ownership lasts at least 2 cycles.
REQ-023 OWN: done accepted with hold counter >= 2 SHALL cause a transition to RELEASE.
REQ-024 OWN: ignore deassertion of the owner's req and any change to op_x until release.
REQ-025 RELEASE: lasts exactly one cycle with both grants low, bus_op = NOOP and bus_busy low; update last_owner to the released owner; go to IDLE.
REQ-026 A new grant SHALL rise no earlier than 2 cycles after the cycle done is accepted.
REQ-027 grant_0 and grant_1 SHALL never both be high.
REQ-028 done in IDLE or RELEASE SHALL be ignored.

Reset
REQ-029 While rst is high: state = IDLE, grants = 0, bus_op = 000, bus_owner = 0, bus_busy = 0, timeout_err = 0, hold counter = 0, last_owner = 1 (cpu0 wins first contention).
REQ-030 Reset asserted mid-ownership SHALL drop the grant immediately (asynchronously); the first grant after deassertion follows REQ-018/019.

Configuration
REQ-031 Macro ARB_TIMEOUT_EN defined: in OWN, when the hold counter reaches HOLD_MAX without an accepted done, go to RELEASE and pulse timeout_err for that RELEASE cycle.
REQ-032 ARB_TIMEOUT_EN undefined: no forced release; timeout_err is tied to 0; the hold counter still saturates at 15.

Verification
REQ-033 req_0=1 only, op_0=001, done pulsed 3 cycles after grant -> grant_0 rises 1 cycle after req_0, bus_op=001; RELEASE lasts 1 cycle; IDLE follows.
REQ-034 req_0 and req_1 high together after reset -> cpu0 granted; after done, cpu1 granted 2 cycles later; then cpu0 again (strict alternation).
REQ-035 done pulsed in the first OWN cycle -> ignored, grant held; a second done 1 cycle later -> release.
REQ-036 ARB_TIMEOUT_EN set, HOLD_MAX=4, no done -> grant drops after 4 OWN cycles and timeout_err pulses once; without the macro the grant is held indefinitely.
REQ-037 rst pulsed while grant_1 is high -> all outputs at reset values at once; with both requests high after reset, cpu0 is granted first.
REQ-038 Random req/op/done traffic for 10k cycles -> grants never both high; bus_op stable throughout each OWN.
